// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - ID-side bus between the decode stage and the multiply/divide unit
//
// Purpose: groups the instruction/operand inputs and the stall/result outputs of mdu_ctrl.
// Signals:
//   flush        - abort any in-flight op and suppress this cycle's issue
//   valid_in     - ID holds a valid instruction this cycle
//   op_code      - instruction [31:26]
//   funct        - instruction [5:0]
//   rs_data      - rs operand (dividend / multiplicand / MT source)
//   rt_data      - rt operand (divisor / multiplier)
//   stall_req    - hold ID and earlier stages
//   busy         - sequencer not idle
//   result       - MFHI/MFLO read data
//   result_valid - result meaningful this cycle
//   hi, lo       - current HI/LO registers
// Modports: master (ID side), slave (mdu_ctrl).

interface mdu_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             valid_in;
  logic [5:0]       op_code;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             stall_req;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output flush, valid_in, op_code, funct, rs_data, rt_data,
    input  stall_req, busy, result, result_valid, hi, lo
  );

  modport slave (
    input  flush, valid_in, op_code, funct, rs_data, rt_data,
    output stall_req, busy, result, result_valid, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle multiply/divide unit owning HI/LO and its sequencing FSM
//
// Purpose: decodes SPECIAL MULT/MULTU/DIV/DIVU/MFHI/MTHI/MFLO/MTLO, sequences the
//   multi-cycle ops and stalls the pipeline while one is in flight.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous reset, active-high
//   bus - mdu_ctrl_if.slave (operands/instruction in, stall/result/HI/LO out)
// Parameters: WIDTH (even, >= 8), MUL_LATENCY (>= 2, issue cycle included).
// Optional feature: define MDU_MADD_EN to decode SPECIAL2 MADD/MADDU/MSUB/MSUBU,
//   which add an accumulate state (MACC) after MUL.

module mdu_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 3
) (
  input logic       clk,
  input logic       rst,
  mdu_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + MUL_LATENCY) + 1;

  typedef enum logic [2:0] {
    IDLE, MUL, DIV_ITER, DIV_FIX
`ifdef MDU_MADD_EN
    , MACC
`endif
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   quo_q, rem_q, dvsr_q;
  logic               q_neg_q, r_neg_q, div_zero_q;
`ifdef MDU_MADD_EN
  logic               acc_q, sub_q;
`endif

  // Instruction decode
  logic special, dec_mult, dec_multu, dec_div, dec_divu;
  logic dec_mfhi, dec_mflo, dec_mthi, dec_mtlo;
  logic mul_any, div_any, mul_signed, idle, mul_issue, div_issue;

  assign special   = bus.valid_in && (bus.op_code == 6'h00);
  assign dec_mult  = special && (bus.funct == 6'h18);
  assign dec_multu = special && (bus.funct == 6'h19);
  assign dec_div   = special && (bus.funct == 6'h1A);
  assign dec_divu  = special && (bus.funct == 6'h1B);
  assign dec_mfhi  = special && (bus.funct == 6'h10);
  assign dec_mthi  = special && (bus.funct == 6'h11);
  assign dec_mflo  = special && (bus.funct == 6'h12);
  assign dec_mtlo  = special && (bus.funct == 6'h13);

`ifdef MDU_MADD_EN
  logic special2, dec_madd, dec_maddu, dec_msub, dec_msubu;
  assign special2  = bus.valid_in && (bus.op_code == 6'h1C);
  assign dec_madd  = special2 && (bus.funct == 6'h00);
  assign dec_maddu = special2 && (bus.funct == 6'h01);
  assign dec_msub  = special2 && (bus.funct == 6'h04);
  assign dec_msubu = special2 && (bus.funct == 6'h05);
  assign mul_any    = dec_mult || dec_multu || dec_madd || dec_maddu || dec_msub || dec_msubu;
  assign mul_signed = dec_mult || dec_madd || dec_msub;
`else
  assign mul_any    = dec_mult || dec_multu;
  assign mul_signed = dec_mult;
`endif

  assign div_any   = dec_div || dec_divu;
  assign idle      = (state == IDLE);
  assign mul_issue = idle && !bus.flush && mul_any;
  assign div_issue = idle && !bus.flush && div_any;

  // Full product computed in the issue cycle; the MUL state only pads latency.
  logic [2*WIDTH-1:0] mul_a, mul_b, mul_prod;
  assign mul_a = mul_signed ? {{WIDTH{bus.rs_data[WIDTH-1]}}, bus.rs_data}
                            : {{WIDTH{1'b0}}, bus.rs_data};
  assign mul_b = mul_signed ? {{WIDTH{bus.rt_data[WIDTH-1]}}, bus.rt_data}
                            : {{WIDTH{1'b0}}, bus.rt_data};
  assign mul_prod = mul_a * mul_b;

  // Divide operates on magnitudes; signs are re-applied in DIV_FIX.
  // MIN / -1 needs no special case: |MIN| is 2^(WIDTH-1) unsigned, and negating
  // that quotient wraps back to MIN with a zero remainder.
  logic             rs_neg, rt_neg, rt_zero;
  logic [WIDTH-1:0] rs_abs, rt_abs;
  assign rs_neg  = dec_div && bus.rs_data[WIDTH-1];
  assign rt_neg  = dec_div && bus.rt_data[WIDTH-1];
  assign rs_abs  = rs_neg ? -bus.rs_data : bus.rs_data;
  assign rt_abs  = rt_neg ? -bus.rt_data : bus.rt_data;
  assign rt_zero = (bus.rt_data == '0);

  // One restoring-division step: shift the next dividend bit into the remainder
  // and subtract the divisor when it fits.
  logic [WIDTH:0]   trial;
  logic             trial_ge;
  logic [WIDTH-1:0] trial_diff, rem_step;
  assign trial      = {rem_q, quo_q[WIDTH-1]};
  assign trial_ge   = trial >= {1'b0, dvsr_q};
  assign trial_diff = trial[WIDTH-1:0] - dvsr_q;
  assign rem_step   = trial_ge ? trial_diff : trial[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (mul_issue)      state_next = MUL;
        else if (div_issue) state_next = DIV_ITER;
      end
      MUL: begin
        if (cnt == '0) begin
`ifdef MDU_MADD_EN
          state_next = acc_q ? MACC : IDLE;
`else
          state_next = IDLE;
`endif
        end
      end
      DIV_ITER: if (cnt == '0) state_next = DIV_FIX;
      DIV_FIX:  state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  always_comb begin
    bus.stall_req    = 1'b0;
    bus.busy         = 1'b0;
    bus.result       = '0;
    bus.result_valid = 1'b0;
    if (!rst) begin
      bus.busy      = !idle;
      bus.stall_req = !idle || mul_issue || div_issue;
      if (idle && dec_mfhi) begin
        bus.result       = hi_q;
        bus.result_valid = 1'b1;
      end else if (idle && dec_mflo) begin
        bus.result       = lo_q;
        bus.result_valid = 1'b1;
      end
    end
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

  // A flush drops everything this cycle: no issue, no MT write, no late HI/LO write.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      prod_q     <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
`ifdef MDU_MADD_EN
      acc_q      <= 1'b0;
      sub_q      <= 1'b0;
`endif
    end else if (!bus.flush) begin
      case (state)
        IDLE: begin
          if (dec_mthi) hi_q <= bus.rs_data;
          if (dec_mtlo) lo_q <= bus.rs_data;
          if (mul_any) begin
            prod_q <= mul_prod;
            cnt    <= CNT_W'(MUL_LATENCY - 2);
`ifdef MDU_MADD_EN
            acc_q  <= !(dec_mult || dec_multu);
            sub_q  <= dec_msub || dec_msubu;
`endif
          end
          if (div_any) begin
            quo_q      <= rs_abs;
            rem_q      <= '0;
            // On divide-by-zero the divisor register carries rs through to HI;
            // the iterations still run for fixed latency and their result is dropped.
            dvsr_q     <= rt_zero ? bus.rs_data : rt_abs;
            q_neg_q    <= rs_neg ^ rt_neg;
            r_neg_q    <= rs_neg;
            div_zero_q <= rt_zero;
            cnt        <= CNT_W'(WIDTH - 1);
          end
        end
        MUL: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
`ifdef MDU_MADD_EN
            if (!acc_q) {hi_q, lo_q} <= prod_q;
`else
            {hi_q, lo_q} <= prod_q;
`endif
          end
        end
        DIV_ITER: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          quo_q <= {quo_q[WIDTH-2:0], trial_ge};
          rem_q <= rem_step;
        end
        DIV_FIX: begin
          if (div_zero_q) begin
            lo_q <= '1;
            hi_q <= dvsr_q;
          end else begin
            lo_q <= q_neg_q ? -quo_q : quo_q;
            hi_q <= r_neg_q ? -rem_q : rem_q;
          end
        end
`ifdef MDU_MADD_EN
        MACC: begin
          if (sub_q) {hi_q, lo_q} <= {hi_q, lo_q} - prod_q;
          else       {hi_q, lo_q} <= {hi_q, lo_q} + prod_q;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed self-checking bench for mdu_ctrl (WIDTH=32, MUL_LATENCY=3)

module tb_mdu_ctrl;

  localparam int W = 32;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  mdu_ctrl_if #(.WIDTH(W)) bus ();

  mdu_ctrl #(.WIDTH(W), .MUL_LATENCY(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    bus.valid_in = v;
    bus.op_code  = op;
    bus.funct    = fn;
    bus.rs_data  = a;
    bus.rt_data  = b;
  endtask

  // Issue one instruction, count stall cycles (bounded), then check HI/LO once idle.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b, input int exp_stall,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int stalls;
    stalls = 0;
    @(negedge clk);
    drive(1'b1, op, fn, a, b);
    #1;
    for (int i = 0; i < 100; i++) begin
      if (!bus.stall_req) break;
      stalls++;
      @(negedge clk);
      drive(1'b0, 6'h00, 6'h00, '0, '0);
      #1;
    end
    check({tag, "/stall"}, 64'(stalls), 64'(exp_stall));
    check({tag, "/busy"}, 64'(bus.busy), 64'd0);
    check({tag, "/hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, "/lo"}, 64'(bus.lo), 64'(exp_lo));
    @(negedge clk);
    drive(1'b0, 6'h00, 6'h00, '0, '0);
  endtask

  initial begin
    bus.flush = 1'b0;
    drive(1'b1, 6'h00, F_MFHI, '0, '0);

    // Reset: outputs gated low even with MFHI / MULT presented.
    @(negedge clk);
    #1;
    check("rst/result_valid", 64'(bus.result_valid), 64'd0);
    check("rst/result", 64'(bus.result), 64'd0);
    @(negedge clk);
    drive(1'b1, 6'h00, F_MULT, 32'd3, 32'd3);
    #1;
    check("rst/stall_req", 64'(bus.stall_req), 64'd0);
    check("rst/busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 6'h00, 6'h00, '0, '0);
    #1;
    check("rst/hi", 64'(bus.hi), 64'd0);
    check("rst/lo", 64'(bus.lo), 64'd0);
    check("rst/idle_busy", 64'(bus.busy), 64'd0);

    // Multiply and divide vectors.
    run_op("mult",     6'h00, F_MULT,  32'hFFFFFFFE, 32'h3, 3,  32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu",    6'h00, F_MULTU, 32'hFFFFFFFE, 32'h3, 3,  32'h00000002, 32'hFFFFFFFA);
    run_op("div_neg",  6'h00, F_DIV,   32'hFFFFFFF9, 32'h2, 34, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_negd", 6'h00, F_DIV,   32'd7, 32'hFFFFFFFE, 34, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu",     6'h00, F_DIVU,  32'd7, 32'd2,        34, 32'h00000001, 32'h00000003);
    run_op("div_zero", 6'h00, F_DIV,   32'd5, 32'd0,        34, 32'h00000005, 32'hFFFFFFFF);
    run_op("div_ovf",  6'h00, F_DIV,   32'h80000000, 32'hFFFFFFFF, 34, 32'h0, 32'h80000000);
    run_op("nop_add",  6'h00, 6'h20,   32'd9, 32'd9,        0,  32'h0, 32'h80000000);

    // MT followed by MF returns the new value with no stall.
    @(negedge clk);
    drive(1'b1, 6'h00, F_MTLO, 32'h1234, '0);
    #1;
    check("mtlo/stall_req", 64'(bus.stall_req), 64'd0);
    @(negedge clk);
    drive(1'b1, 6'h00, F_MFLO, '0, '0);
    #1;
    check("mflo/result", 64'(bus.result), 64'h1234);
    check("mflo/result_valid", 64'(bus.result_valid), 64'd1);
    check("mflo/stall_req", 64'(bus.stall_req), 64'd0);
    @(negedge clk);
    drive(1'b1, 6'h00, F_MTHI, 32'h5678, '0);
    @(negedge clk);
    drive(1'b1, 6'h00, F_MFHI, '0, '0);
    #1;
    check("mfhi/result", 64'(bus.result), 64'h5678);

    // Instructions presented while busy are ignored.
    @(negedge clk);
    drive(1'b1, 6'h00, F_MULT, 32'd5, 32'd6);
    @(negedge clk);
    drive(1'b1, 6'h00, F_MTHI, 32'hDEAD, '0);
    @(negedge clk);
    drive(1'b1, 6'h00, F_MFLO, '0, '0);
    #1;
    check("busy_mf/result_valid", 64'(bus.result_valid), 64'd0);
    check("busy_mf/result", 64'(bus.result), 64'd0);
    @(negedge clk);
    drive(1'b0, 6'h00, 6'h00, '0, '0);
    #1;
    check("busy_mt/hi", 64'(bus.hi), 64'd0);
    check("busy_mt/lo", 64'(bus.lo), 64'd30);

    // Flush mid-divide leaves preset HI/LO untouched.
    @(negedge clk);
    drive(1'b1, 6'h00, F_MTHI, 32'hA5, '0);
    @(negedge clk);
    drive(1'b1, 6'h00, F_MTLO, 32'hA5, '0);
    @(negedge clk);
    drive(1'b1, 6'h00, F_DIV, 32'd100, 32'd7);
    repeat (10) begin
      @(negedge clk);
      drive(1'b0, 6'h00, 6'h00, '0, '0);
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flush/stall_req", 64'(bus.stall_req), 64'd0);
    check("flush/busy", 64'(bus.busy), 64'd0);
    repeat (40) @(negedge clk);
    #1;
    check("flush/hi", 64'(bus.hi), 64'hA5);
    check("flush/lo", 64'(bus.lo), 64'hA5);

    // Flush in the issue cycle suppresses the issue and MT writes.
    @(negedge clk);
    bus.flush = 1'b1;
    drive(1'b1, 6'h00, F_MULT, 32'd3, 32'd3);
    #1;
    check("flush_issue/stall_req", 64'(bus.stall_req), 64'd0);
    @(negedge clk);
    drive(1'b1, 6'h00, F_MTLO, 32'h77, '0);
    #1;
    check("flush_issue/busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    drive(1'b0, 6'h00, 6'h00, '0, '0);
    #1;
    check("flush_mt/lo", 64'(bus.lo), 64'hA5);
    check("flush_issue/busy2", 64'(bus.busy), 64'd0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    drive(1'b1, 6'h00, F_MULT, 32'h10, 32'h10);
    @(negedge clk);
    drive(1'b0, 6'h00, 6'h00, '0, '0);
    rst = 1'b1;
    #1;
    check("rst_mid/busy_in_rst", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid/hi", 64'(bus.hi), 64'd0);
    check("rst_mid/lo", 64'(bus.lo), 64'd0);
    check("rst_mid/busy", 64'(bus.busy), 64'd0);

    // SPECIAL2 multiply-accumulate (or no-op when the feature is absent).
    @(negedge clk);
    drive(1'b1, 6'h00, F_MTLO, 32'd1, '0);
    @(negedge clk);
    drive(1'b0, 6'h00, 6'h00, '0, '0);
`ifdef MDU_MADD_EN
    run_op("madd",  6'h1C, 6'h00, 32'd2, 32'd3, 4, 32'h00000000, 32'h00000007);
    run_op("msubu", 6'h1C, 6'h05, 32'd1, 32'd8, 4, 32'hFFFFFFFF, 32'hFFFFFFFF);
`else
    run_op("madd",  6'h1C, 6'h00, 32'd2, 32'd3, 0, 32'h00000000, 32'h00000001);
    run_op("msubu", 6'h1C, 6'h05, 32'd1, 32'd8, 0, 32'h00000000, 32'h00000001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
